snake_dir_ctrl: RTL and testbench
=================================

Name: snake_dir_ctrl

Overview:
- Game-control stage directly upstream of the snake movement/render block.
- Turns raw direction and centre push-buttons into the registered 3-bit move code and the animate strobe that the movement logic samples on clk4.
- Runs the start/pause/dead state machine and rejects 180-degree reversals.
- Buffers up to two queued turns, so quick button sequences between steps are not lost.

Parameters:
- STEP_DIV, 1, number of clk4 cycles per snake step while running (range 1-15).

Ports:
- clk4  in  1  game tick clock (divided clock shared with the movement logic)
- rst  in  1  reset, synchronous, active-high
- btn_up  in  1  level, already synchronised/debounced
- btn_down  in  1  level
- btn_left  in  1  level
- btn_right  in  1  level
- btn_center  in  1  level; start/pause
- game_over  in  1  level from the lose-condition logic
- move  out  3  000 right, 001 up, 010 left, 011 down, 100 hold
- animate  out  1  high = movement logic applies move this clk4 edge
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DEAD
- q_count  out  2  queued turns, 0..2

Behaviour:
- Reset values: state=IDLE, move=100, animate=0, q_count=0, dir=000 (right), step counter=0, all button history registers=0.
- Edge detection:
  - Each button is registered once per clk4.
  - A press is current=1 and previous=0.
  - A held button generates exactly one press.
- Direction press priority when several arrive in the same cycle: up > down > left > right. Only the highest is used; the rest are discarded.
- FSM transitions, evaluated each clk4:
  - IDLE: centre press -> RUN. dir=000, queue cleared, step counter=0. Direction presses are ignored.
  - RUN: game_over=1 -> DEAD, which has priority over centre. Centre press -> PAUSE.
  - PAUSE: game_over=1 -> DEAD. Centre press -> RUN; the step counter resumes from its held value.
  - DEAD: the only exit is rst. Direction and centre presses are ignored.
- Step timing:
  - In RUN, step counter counts 0..STEP_DIV-1 and wraps.
  - A step cycle is one where counter==STEP_DIV-1.
  - In PAUSE the counter holds. STEP_DIV=1 makes every RUN cycle a step.
- Turn queue: 2-entry FIFO, accepted in RUN and PAUSE.
  - Reference direction = tail entry if q_count>0, else dir.
  - A press is pushed only if it differs from the reference, is not the reference's opposite (right/left, up/down), and the queue is not full (q_count=2). Otherwise it is dropped silently.
- On a step cycle, if q_count>0, the head pops into dir before move is formed.
- Simultaneous pop and push in one cycle:
  - The reference is the pre-pop tail.
  - Both operations occur, so a full queue stays at 2 and q_count=1 stays at 1.
- Outputs are registered, one clk4 latency:
  - On a step-cycle edge: move <= dir after any pop, animate <= 1.
  - On every other edge, and in all states other than RUN: animate <= 0.
  - move <= dir in RUN non-step cycles.
  - move <= 100 in IDLE, PAUSE and DEAD.
- Mid-operation reset: rst overrides everything on that edge, including a simultaneous step or press. All reset values appear after the edge.
- game_over while in IDLE is ignored.

Test Plan:
- rst=1 for 2 cycles, then hold centre low for 5 cycles -> state=00, move=100, animate=0 throughout.
- STEP_DIV=1, centre pulse -> next edge state=01. Following edge: move=000, animate=1. Stays 1 every cycle.
- RUN heading right; press up then left on consecutive non-step cycles (STEP_DIV=4) -> q_count 1, then 2. Next two steps output move=001 then 010.
- RUN heading right; press left -> dropped: q_count=0, move stays 000.
- Queue full (up, left); press down -> dropped, q_count=2. Press down on a step cycle instead -> pop and push together, q_count stays 2.
- Centre while RUN -> PAUSE, move=100, animate=0, step counter held. game_over=1 -> state=11. Later centre press -> still 11. rst -> state=00.

Source files
------------

// File: rtl/snake_dir_ctrl.sv
// rtl/snake_dir_ctrl.sv - snake game control: start/pause/dead FSM, turn queue, step pacing
// Produces the registered move code and animate strobe sampled by the movement logic on clk4.
module snake_dir_ctrl #(
    parameter int STEP_DIV = 1
) (
    input  logic       clk4,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_center,
    input  logic       game_over,
    output logic [2:0] move,
    output logic       animate,
    output logic [1:0] state,
    output logic [1:0] q_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DEAD  = 2'b11
    } state_t;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_UP    = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;
    localparam logic [2:0] MOVE_HOLD = 3'b100;
    localparam logic [3:0] STEP_LAST = 4'(STEP_DIV - 1);

    state_t     state_q, state_d;
    logic [4:0] btn_q, btn_d;
    logic [1:0] dir_q, dir_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] slot0_q, slot0_d;
    logic [1:0] slot1_q, slot1_d;
    logic [1:0] q_count_q, q_count_d;
    logic [2:0] move_q, move_d;
    logic       animate_q, animate_d;

    logic [4:0] btn_now;
    logic [4:0] press;
    logic       dir_press;
    logic [1:0] new_dir;
    logic [1:0] ref_dir;
    logic       in_run;
    logic       accept;
    logic       step;
    logic       pop;
    logic       push;

    always_comb begin
        btn_now = {btn_up, btn_down, btn_left, btn_right, btn_center};
        press   = btn_now & ~btn_q;

        dir_press = 1'b1;
        new_dir   = DIR_RIGHT;
        if (press[4]) begin
            new_dir = DIR_UP;
        end else if (press[3]) begin
            new_dir = DIR_DOWN;
        end else if (press[2]) begin
            new_dir = DIR_LEFT;
        end else if (press[1]) begin
            new_dir = DIR_RIGHT;
        end else begin
            dir_press = 1'b0;
        end

        in_run = (state_q == ST_RUN);
        accept = in_run || (state_q == ST_PAUSE);
        step   = in_run && (cnt_q == STEP_LAST);
        pop    = step && (q_count_q != 2'd0);

        // Turns are validated against the last queued turn, not the current heading
        case (q_count_q)
            2'd0:    ref_dir = dir_q;
            2'd1:    ref_dir = slot0_q;
            default: ref_dir = slot1_q;
        endcase

        push = accept && dir_press && (new_dir != ref_dir)
            && (new_dir != (ref_dir ^ 2'b10))
            && ((q_count_q != 2'd2) || pop);

        state_d   = state_q;
        btn_d     = btn_now;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        slot0_d   = slot0_q;
        slot1_d   = slot1_q;
        q_count_d = q_count_q;
        move_d    = MOVE_HOLD;
        animate_d = 1'b0;

        if (pop) begin
            dir_d = slot0_q;
        end

        case ({pop, push})
            2'b10: begin
                slot0_d   = slot1_q;
                q_count_d = q_count_q - 2'd1;
            end
            2'b01: begin
                if (q_count_q == 2'd0) begin
                    slot0_d = new_dir;
                end else begin
                    slot1_d = new_dir;
                end
                q_count_d = q_count_q + 2'd1;
            end
            2'b11: begin
                if (q_count_q == 2'd2) begin
                    slot0_d = slot1_q;
                    slot1_d = new_dir;
                end else begin
                    slot0_d = new_dir;
                end
            end
            default: ;
        endcase

        if (in_run) begin
            move_d    = {1'b0, dir_d};
            animate_d = step;
            cnt_d     = step ? 4'd0 : cnt_q + 4'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (press[0]) begin
                    state_d   = ST_RUN;
                    dir_d     = DIR_RIGHT;
                    cnt_d     = 4'd0;
                    q_count_d = 2'd0;
                    slot0_d   = DIR_RIGHT;
                    slot1_d   = DIR_RIGHT;
                end
            end
            ST_RUN: begin
                if (game_over) begin
                    state_d = ST_DEAD;
                end else if (press[0]) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (game_over) begin
                    state_d = ST_DEAD;
                end else if (press[0]) begin
                    state_d = ST_RUN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk4) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            btn_q     <= 5'd0;
            dir_q     <= DIR_RIGHT;
            cnt_q     <= 4'd0;
            slot0_q   <= DIR_RIGHT;
            slot1_q   <= DIR_RIGHT;
            q_count_q <= 2'd0;
            move_q    <= MOVE_HOLD;
            animate_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            btn_q     <= btn_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            slot0_q   <= slot0_d;
            slot1_q   <= slot1_d;
            q_count_q <= q_count_d;
            move_q    <= move_d;
            animate_q <= animate_d;
        end
    end

    assign move    = move_q;
    assign animate = animate_q;
    assign state   = state_q;
    assign q_count = q_count_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb/tb_snake_dir_ctrl.sv - directed vector table plus randomized run against a reference model
// Two instances (STEP_DIV=4 and STEP_DIV=1) share the same button stimulus.
module tb_snake_dir_ctrl;

    logic       clk4 = 1'b0;
    logic       rst  = 1'b1;
    logic       go   = 1'b0;
    logic [4:0] btns = 5'd0;

    logic [2:0] move_a, move_b;
    logic       animate_a, animate_b;
    logic [1:0] state_a, state_b;
    logic [1:0] qc_a, qc_b;

    always #5 clk4 = ~clk4;

    snake_dir_ctrl #(.STEP_DIV(4)) dut_a (
        .clk4(clk4), .rst(rst),
        .btn_up(btns[4]), .btn_down(btns[3]), .btn_left(btns[2]),
        .btn_right(btns[1]), .btn_center(btns[0]), .game_over(go),
        .move(move_a), .animate(animate_a), .state(state_a), .q_count(qc_a)
    );

    snake_dir_ctrl #(.STEP_DIV(1)) dut_b (
        .clk4(clk4), .rst(rst),
        .btn_up(btns[4]), .btn_down(btns[3]), .btn_left(btns[2]),
        .btn_right(btns[1]), .btn_center(btns[0]), .game_over(go),
        .move(move_b), .animate(animate_b), .state(state_b), .q_count(qc_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0] btn;
        logic       g;
        logic       r;
        logic [1:0] st;
        logic [2:0] mv;
        logic       an;
        logic [1:0] qc;
    } vec_t;

    vec_t tbl[$];

    // Reference model: index 0 mirrors STEP_DIV=4, index 1 mirrors STEP_DIV=1.
    // States: 0 idle, 1 run, 2 pause, 3 dead. Directions: 0 right, 1 up, 2 left, 3 down.
    int         m_st[2], m_dir[2], m_cnt[2], m_qn[2], m_mv[2], m_an[2];
    int         m_qd[2][2];
    logic [4:0] m_prev = 5'd0;

    localparam logic [4:0] U = 5'b10000;
    localparam logic [4:0] D = 5'b01000;
    localparam logic [4:0] L = 5'b00100;
    localparam logic [4:0] R = 5'b00010;
    localparam logic [4:0] C = 5'b00001;
    localparam logic [4:0] N = 5'b00000;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [4:0] pr;
        int         nd;
        bit         have;
        pr     = btns & ~m_prev;
        m_prev = rst ? 5'd0 : btns;
        have   = 1'b1;
        if (pr[4])      nd = 1;
        else if (pr[3]) nd = 3;
        else if (pr[2]) nd = 2;
        else if (pr[1]) nd = 0;
        else begin
            nd   = 0;
            have = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            int div, rf, st0;
            bit step, pop, push;
            if (rst) begin
                m_st[i] = 0; m_dir[i] = 0; m_cnt[i] = 0; m_qn[i] = 0;
                m_mv[i] = 4; m_an[i] = 0;
                continue;
            end
            div  = (i == 0) ? 4 : 1;
            st0  = m_st[i];
            step = (st0 == 1) && (m_cnt[i] == div - 1);
            pop  = step && (m_qn[i] > 0);
            rf   = (m_qn[i] > 0) ? m_qd[i][m_qn[i] - 1] : m_dir[i];
            push = have && (st0 == 1 || st0 == 2) && (nd != rf)
                && (nd != (rf + 2) % 4) && (m_qn[i] < 2 || pop);
            if (pop) begin
                m_dir[i]   = m_qd[i][0];
                m_qd[i][0] = m_qd[i][1];
                m_qn[i]--;
            end
            if (push) begin
                m_qd[i][m_qn[i]] = nd;
                m_qn[i]++;
            end
            if (st0 == 1) begin
                m_mv[i]  = m_dir[i];
                m_an[i]  = step ? 1 : 0;
                m_cnt[i] = (m_cnt[i] + 1) % div;
            end else begin
                m_mv[i] = 4;
                m_an[i] = 0;
            end
            case (st0)
                0: if (pr[0]) begin
                    m_st[i] = 1; m_dir[i] = 0; m_qn[i] = 0; m_cnt[i] = 0;
                end
                1: if (go) m_st[i] = 3; else if (pr[0]) m_st[i] = 2;
                2: if (go) m_st[i] = 3; else if (pr[0]) m_st[i] = 1;
                default: ;
            endcase
        end
    endtask

    task automatic compare_model();
        check("a_state",   int'(state_a),   m_st[0]);
        check("a_move",    int'(move_a),    m_mv[0]);
        check("a_animate", int'(animate_a), m_an[0]);
        check("a_q_count", int'(qc_a),      m_qn[0]);
        check("b_state",   int'(state_b),   m_st[1]);
        check("b_move",    int'(move_b),    m_mv[1]);
        check("b_animate", int'(animate_b), m_an[1]);
        check("b_q_count", int'(qc_b),      m_qn[1]);
    endtask

    task automatic tick();
        @(posedge clk4);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic add(input logic [4:0] b, input logic g, input logic r,
                       input logic [1:0] s, input logic [2:0] m, input logic a,
                       input logic [1:0] q);
        vec_t v;
        v.btn = b; v.g = g; v.r = r; v.st = s; v.mv = m; v.an = a; v.qc = q;
        tbl.push_back(v);
    endtask

    initial begin
        // Expected values below are for the STEP_DIV=4 instance
        add(N, 0, 1, 2'd0, 3'd4, 0, 2'd0);
        add(N, 0, 1, 2'd0, 3'd4, 0, 2'd0);
        add(N, 0, 0, 2'd0, 3'd4, 0, 2'd0);
        add(N, 0, 0, 2'd0, 3'd4, 0, 2'd0);
        add(N, 0, 0, 2'd0, 3'd4, 0, 2'd0);
        add(U, 0, 0, 2'd0, 3'd4, 0, 2'd0);
        add(N, 0, 0, 2'd0, 3'd4, 0, 2'd0);
        add(C, 0, 0, 2'd1, 3'd4, 0, 2'd0);
        add(U, 0, 0, 2'd1, 3'd0, 0, 2'd1);
        add(L, 0, 0, 2'd1, 3'd0, 0, 2'd2);
        add(N, 0, 0, 2'd1, 3'd0, 0, 2'd2);
        add(N, 0, 0, 2'd1, 3'd1, 1, 2'd1);
        add(N, 0, 0, 2'd1, 3'd1, 0, 2'd1);
        add(N, 0, 0, 2'd1, 3'd1, 0, 2'd1);
        add(N, 0, 0, 2'd1, 3'd1, 0, 2'd1);
        add(N, 0, 0, 2'd1, 3'd2, 1, 2'd0);
        add(R, 0, 0, 2'd1, 3'd2, 0, 2'd0);
        add(N, 0, 0, 2'd1, 3'd2, 0, 2'd0);
        add(N, 0, 0, 2'd1, 3'd2, 0, 2'd0);
        add(N, 0, 0, 2'd1, 3'd2, 1, 2'd0);
        add(U, 0, 0, 2'd1, 3'd2, 0, 2'd1);
        add(L, 0, 0, 2'd1, 3'd2, 0, 2'd2);
        add(D, 0, 0, 2'd1, 3'd2, 0, 2'd2);
        add(U, 0, 0, 2'd1, 3'd1, 1, 2'd2);
        add(C, 0, 0, 2'd2, 3'd1, 0, 2'd2);
        add(N, 0, 0, 2'd2, 3'd4, 0, 2'd2);
        add(N, 0, 0, 2'd2, 3'd4, 0, 2'd2);
        add(C, 0, 0, 2'd1, 3'd4, 0, 2'd2);
        add(N, 0, 0, 2'd1, 3'd1, 0, 2'd2);
        add(N, 0, 0, 2'd1, 3'd1, 0, 2'd2);
        add(N, 0, 0, 2'd1, 3'd2, 1, 2'd1);
        add(C, 0, 0, 2'd2, 3'd2, 0, 2'd1);
        add(N, 1, 0, 2'd3, 3'd4, 0, 2'd1);
        add(C, 0, 0, 2'd3, 3'd4, 0, 2'd1);
        add(U, 0, 0, 2'd3, 3'd4, 0, 2'd1);
        add(N, 0, 1, 2'd0, 3'd4, 0, 2'd0);
        add(N, 1, 0, 2'd0, 3'd4, 0, 2'd0);
        add(C, 0, 0, 2'd1, 3'd4, 0, 2'd0);
        add(N, 0, 0, 2'd1, 3'd0, 0, 2'd0);
        add(C, 1, 0, 2'd3, 3'd0, 0, 2'd0);
        add(N, 0, 0, 2'd3, 3'd4, 0, 2'd0);

        #2;
        for (int k = 0; k < tbl.size(); k++) begin
            btns = tbl[k].btn;
            go   = tbl[k].g;
            rst  = tbl[k].r;
            tick();
            check($sformatf("row%0d_state", k),   int'(state_a),   int'(tbl[k].st));
            check($sformatf("row%0d_move", k),    int'(move_a),    int'(tbl[k].mv));
            check($sformatf("row%0d_animate", k), int'(animate_a), int'(tbl[k].an));
            check($sformatf("row%0d_q_count", k), int'(qc_a),      int'(tbl[k].qc));
        end

        // Randomized run; both instances follow the reference model
        btns = N; go = 1'b0; rst = 1'b1;
        tick();
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 79) == 0);
            go   = ($urandom_range(0, 149) == 0);
            btns = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 11) == 0)};
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
